// File: rtl/alu_uart_if.sv
// alu_uart_if: collects operand A, operand B and an opcode from a byte-wide
// UART receiver, drives them to a registered ALU, then hands the ALU result
// to the UART transmitter and waits for it to finish.
// Optional feature: define ALU_UART_IF_TIMEOUT_EN to abandon a frame (and
// pulse o_error) when no byte arrives for TIMEOUT cycles in GET_B or GET_OP.
module alu_uart_if #(
    parameter int N       = 8,
    parameter int NSel    = 6,
    parameter int TIMEOUT = 1000
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [N-1:0]    i_rx_data,
    input  logic            i_rx_done,
    input  logic [N-1:0]    i_alu_result,
    input  logic            i_tx_done,
    output logic [N-1:0]    o_alu_A,
    output logic [N-1:0]    o_alu_B,
    output logic [NSel-1:0] o_alu_Op,
    output logic [N-1:0]    o_tx_data,
    output logic            o_tx_start,
    output logic            o_busy,
    output logic            o_error
);

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    alu_a_q, alu_a_d;
    logic [N-1:0]    alu_b_q, alu_b_d;
    logic [NSel-1:0] alu_op_q, alu_op_d;
    logic [N-1:0]    tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    // One bit is enough: EXEC waits one edge for the ALU's internal register.
    logic            exec_cnt_q, exec_cnt_d;

`ifdef ALU_UART_IF_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          error_q, error_d;
`else
    // TIMEOUT only matters with the timeout feature; fold it into a sink.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        exec_cnt_d = exec_cnt_q;
`ifdef ALU_UART_IF_TIMEOUT_EN
        to_cnt_d   = '0;
        error_d    = 1'b0;
`endif
        case (state_q)
            GET_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = GET_OP;
                end
`ifdef ALU_UART_IF_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = GET_A;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            GET_OP: begin
                if (i_rx_done) begin
                    alu_op_d   = i_rx_data[NSel-1:0];
                    exec_cnt_d = 1'b0;
                    state_d    = EXEC;
                end
`ifdef ALU_UART_IF_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    state_d = GET_A;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            EXEC: begin
                if (!exec_cnt_q) begin
                    exec_cnt_d = 1'b1;
                end else begin
                    tx_data_d  = i_alu_result;
                    tx_start_d = 1'b1;
                    state_d    = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
        busy_d = (state_d != GET_A);
    end

    // State and all outputs registered; reset clears everything at once.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= GET_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            exec_cnt_q <= 1'b0;
`ifdef ALU_UART_IF_TIMEOUT_EN
            to_cnt_q   <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            exec_cnt_q <= exec_cnt_d;
`ifdef ALU_UART_IF_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            error_q    <= error_d;
`endif
        end
    end

    assign o_alu_A    = alu_a_q;
    assign o_alu_B    = alu_b_q;
    assign o_alu_Op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
`ifdef ALU_UART_IF_TIMEOUT_EN
    assign o_error    = error_q;
`else
    assign o_error    = 1'b0;
`endif

endmodule
